// File: rtl/reg_bus_arbiter_pkg.sv
// reg_arb_pkg: shared state encoding and constants for the register-bus arbiter
package reg_arb_pkg;
  localparam int GNT_W = 3;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, DONE, GAP} state_t;
endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after last grant
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N_MST = 3
) (
  input  logic [N_MST-1:0] req,
  input  logic [GNT_W-1:0] last,
  output logic [GNT_W-1:0] gnt_id,
  output logic             gnt_vld
);
  // descending offsets so the nearest requester after last is assigned last and wins
  always_comb begin
    gnt_id = '0;
    gnt_vld = 1'b0;
    for (int k = N_MST; k >= 1; k--)
      for (int i = 0; i < N_MST; i++)
        if (req[i] && i == (int'(last) + k) % N_MST) begin
          gnt_id = GNT_W'(i);
          gnt_vld = 1'b1;
        end
  end
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of one register-bus slave among N_MST masters,
// one transaction at a time, with read timeout and a post-transaction gap cycle.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int          N_MST    = 3,
  parameter int          AW       = 8,
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_MST-1:0]    M_REQ,
  input  logic [N_MST-1:0]    M_WR,
  input  logic [N_MST*AW-1:0] M_ADR,
  input  logic [N_MST*32-1:0] M_WDAT,
  output logic [N_MST-1:0]    M_ACK,
  output logic [31:0]         M_RDAT,
  output logic                M_ERR,
  output logic                S_WREN,
  output logic [AW-1:0]       S_WADR,
  output logic [31:0]         S_WDAT,
  output logic                S_RDEN,
  output logic [AW-1:0]       S_RADR,
  input  logic [31:0]         S_RDAT,
  input  logic                S_RVLD,
  output logic                BUSY,
  output logic [GNT_W-1:0]    GNT_ID
);
  localparam int CW = $clog2(TIMEOUT);
  state_t state;
  logic [GNT_W-1:0] last, pick_id;
  logic pick_vld, pick_wr;
  logic [AW-1:0] pick_adr;
  logic [31:0] pick_wdat;
  logic [N_MST-1:0] pick_oh, gnt_oh;
  logic [CW-1:0] cnt;
  rr_pick #(.N_MST(N_MST)) u_pick (
    .req    (M_REQ),
    .last   (last),
    .gnt_id (pick_id),
    .gnt_vld(pick_vld)
  );
  always_comb begin
    pick_wr = 1'b0;
    pick_adr = '0;
    pick_wdat = '0;
    pick_oh = '0;
    gnt_oh = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (pick_id == GNT_W'(i)) begin
        pick_wr = M_WR[i];
        pick_adr = M_ADR[i*AW +: AW];
        pick_wdat = M_WDAT[i*32 +: 32];
        pick_oh[i] = 1'b1;
      end
      gnt_oh[i] = GNT_ID == GNT_W'(i);
    end
  end
  // outputs are set on entry to a state so they are visible during that state
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      last <= GNT_W'(N_MST - 1);
      GNT_ID <= '0;
      cnt <= '0;
      BUSY <= 1'b0;
      M_ACK <= '0;
      M_RDAT <= '0;
      M_ERR <= 1'b0;
      S_WREN <= 1'b0;
      S_WADR <= '0;
      S_WDAT <= '0;
      S_RDEN <= 1'b0;
      S_RADR <= '0;
    end else begin
      M_ACK <= '0;
      M_RDAT <= '0;
      M_ERR <= 1'b0;
      S_WREN <= 1'b0;
      S_RDEN <= 1'b0;
      case (state)
        IDLE: if (pick_vld) begin
          last <= pick_id;
          GNT_ID <= pick_id;
          BUSY <= 1'b1;
          if (pick_wr) begin
            state <= WR;
            S_WREN <= 1'b1;
            S_WADR <= pick_adr;
            S_WDAT <= pick_wdat;
            M_ACK <= pick_oh;
          end else begin
            state <= RD_ISSUE;
            S_RDEN <= 1'b1;
            S_RADR <= pick_adr;
          end
        end
        WR: state <= GAP;
        RD_ISSUE: begin
          state <= RD_WAIT;
          cnt <= '0;
        end
        RD_WAIT: begin
          cnt <= cnt + 1'b1;
          if (S_RVLD || cnt == CW'(TIMEOUT - 1)) begin
            state <= DONE;
            M_ACK <= gnt_oh;
            M_RDAT <= S_RVLD ? S_RDAT : ERR_DATA;
            M_ERR <= !S_RVLD;
          end
        end
        DONE: state <= GAP;
        GAP: begin
          state <= IDLE;
          BUSY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: scoreboard bench with a 3-cycle slave model and a
// round-robin reference model that predicts grant order and read data.
`timescale 1ns/1ps
module tb_reg_bus_arbiter;
  import reg_arb_pkg::*;
  localparam int N = 3, AW = 8, TO = 64, AWT = N * AW, DWT = N * 32;
  logic CLK = 1'b0, RST = 1'b1;
  logic [N-1:0] M_REQ = '0, M_WR = '0;
  logic [AWT-1:0] M_ADR = '0;
  logic [DWT-1:0] M_WDAT = '0;
  logic [N-1:0] M_ACK;
  logic [31:0] M_RDAT, S_WDAT, S_RDAT;
  logic M_ERR, S_WREN, S_RDEN, S_RVLD, BUSY;
  logic [AW-1:0] S_WADR, S_RADR;
  logic [GNT_W-1:0] GNT_ID;

  reg_bus_arbiter #(.N_MST(N), .AW(AW), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
    .CLK(CLK), .RST(RST), .M_REQ(M_REQ), .M_WR(M_WR), .M_ADR(M_ADR), .M_WDAT(M_WDAT),
    .M_ACK(M_ACK), .M_RDAT(M_RDAT), .M_ERR(M_ERR), .S_WREN(S_WREN), .S_WADR(S_WADR),
    .S_WDAT(S_WDAT), .S_RDEN(S_RDEN), .S_RADR(S_RADR), .S_RDAT(S_RDAT), .S_RVLD(S_RVLD),
    .BUSY(BUSY), .GNT_ID(GNT_ID)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // slave: RDEN seen at an edge, RVLD driven three cycles after the RDEN cycle
  bit [31:0] smem [64];
  int scnt = 0;
  bit dead = 1'b0, force_rvld = 1'b0;
  always @(posedge CLK) begin
    if (S_WREN) smem[S_WADR[7:2]] <= S_WDAT;
    S_RVLD <= (scnt == 1) || force_rvld;
    S_RDAT <= (scnt == 1) ? smem[S_RADR[7:2]] : 32'h0BAD0BAD;
    scnt <= (S_RDEN && !dead) ? 2 : (scnt > 0 ? scnt - 1 : 0);
  end

  typedef struct { int mst; logic [31:0] rdat; logic err; } ack_t;
  typedef struct { logic [AW-1:0] adr; logic [31:0] dat; } wr_t;
  ack_t aq[$];
  wr_t wq[$];
  logic [AW-1:0] rq[$];
  ack_t e;
  wr_t w;
  int errs = 0, checks = 0, acks = 0, ack_cyc = -1, rden_cyc = -100;
  int mst_acks [N] = '{default: 0};
  int snap [N];
  int ptr = N - 1;
  bit [31:0] rmem [64];
  int t, n, bud;
  logic [N-1:0] mask, wrv;
  logic [AWT-1:0] adrv;
  logic [DWT-1:0] wdv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an ack or strobe
  always begin
    @(posedge CLK);
    #1;
    if (!RST) begin
      if (M_ACK != '0) begin
        acks++;
        ack_cyc = cyc;
        for (int i = 0; i < N; i++) if (M_ACK[i]) mst_acks[i]++;
        if (aq.size() == 0) chk("unexpected_ack", 32'(M_ACK), 32'd0);
        else begin
          e = aq.pop_front();
          chk("ack_onehot", 32'(M_ACK), 32'd1 << e.mst);
          chk("ack_gnt_id", 32'(GNT_ID), 32'(e.mst));
          chk("ack_rdat", M_RDAT, e.rdat);
          chk("ack_err", 32'(M_ERR), 32'(e.err));
        end
      end else if (M_RDAT != '0 || M_ERR) chk("rdat_err_idle", {M_RDAT[30:0], M_ERR}, 32'd0);
      if (S_WREN) begin
        if (wq.size() == 0) chk("unexpected_wren", 32'(S_WADR), 32'd0);
        else begin
          w = wq.pop_front();
          chk("wr_adr", 32'(S_WADR), 32'(w.adr));
          chk("wr_dat", S_WDAT, w.dat);
        end
      end
      if (S_RDEN) begin
        chk("rden_spacing", 32'(cyc - rden_cyc >= 4), 32'd1);
        rden_cyc = cyc;
        if (rq.size() == 0) chk("unexpected_rden", 32'(S_RADR), 32'd0);
        else chk("rd_adr", 32'(S_RADR), 32'(rq.pop_front()));
      end
    end
  end

  // reference model: requesters in mask are served in cyclic order after ptr
  task automatic issue(input logic [N-1:0] m, input logic [N-1:0] wr,
                       input logic [AWT-1:0] adr, input logic [DWT-1:0] wd, input bit to);
    int p;
    p = ptr;
    for (int k = 1; k <= N; k++) begin
      int i;
      logic [AW-1:0] a;
      logic [31:0] d;
      i = (p + k) % N;
      a = adr[i*AW +: AW];
      d = wd[i*32 +: 32];
      if (m[i]) begin
        ptr = i;
        if (wr[i]) begin
          rmem[a[7:2]] = d;
          wq.push_back('{a, d});
          aq.push_back('{i, 32'd0, 1'b0});
        end else begin
          rq.push_back(a);
          if (to) aq.push_back('{i, 32'hDEADBEEF, 1'b1});
          else aq.push_back('{i, rmem[a[7:2]], 1'b0});
        end
      end
    end
    M_WR = wr;
    M_ADR = adr;
    M_WDAT = wd;
    M_REQ = m;
  endtask

  task automatic wait_acks(input logic [N-1:0] m, input int budget);
    int k;
    k = 0;
    while ((M_REQ & m) != '0 && k < budget) begin
      @(negedge CLK);
      k++;
      M_REQ = M_REQ & ~M_ACK;
    end
    if ((M_REQ & m) != '0) begin
      chk("ack_wait_expired", 32'(M_REQ & m), 32'd0);
      M_REQ = '0;
    end
  endtask

  task automatic single(input int i, input bit wr, input logic [AW-1:0] a,
                        input logic [31:0] d, input bit to);
    issue(N'(1) << i, N'(wr) << i, AWT'(a) << (i * AW), DWT'(d) << (i * 32), to);
    wait_acks(N'(1) << i, 200);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ack"}, 32'(M_ACK), 32'd0);
    chk({tag, "_rdat"}, M_RDAT, 32'd0);
    chk({tag, "_err"}, 32'(M_ERR), 32'd0);
    chk({tag, "_wren_rden"}, 32'({S_WREN, S_RDEN}), 32'd0);
    chk({tag, "_wadr_radr"}, 32'({S_WADR, S_RADR}), 32'd0);
    chk({tag, "_wdat"}, S_WDAT, 32'd0);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_gnt_id"}, 32'(GNT_ID), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    chk_idle("reset");
    // write latency and BUSY release
    repeat (3) @(negedge CLK);
    t = cyc;
    single_issue_write: begin
      issue(3'b001, 3'b001, AWT'(8'h04), DWT'(32'h80000001), 1'b0);
    end
    @(negedge CLK);
    M_REQ = '0;
    chk("wr_wren", 32'(S_WREN), 32'd1);
    chk("wr_wadr_t1", 32'(S_WADR), 32'h04);
    chk("wr_wdat_t1", S_WDAT, 32'h80000001);
    chk("wr_ack_cyc", 32'(ack_cyc), 32'(t + 1));
    @(negedge CLK);
    chk("wr_busy_gap", 32'(BUSY), 32'd1);
    @(negedge CLK);
    chk("wr_busy_t3", 32'(BUSY), 32'd0);
    // read through a 3-cycle slave
    single(0, 1'b1, 8'h08, 32'h12345678, 1'b0);
    repeat (3) @(negedge CLK);
    t = cyc;
    issue(3'b010, 3'b000, AWT'(8'h08) << AW, '0, 1'b0);
    @(negedge CLK);
    chk("rd_rden", 32'(S_RDEN), 32'd1);
    chk("rd_rden_cyc", 32'(rden_cyc), 32'(t + 1));
    repeat (3) @(negedge CLK);
    chk("rd_radr_hold", 32'(S_RADR), 32'h08);
    chk("rd_rden_low", 32'(S_RDEN), 32'd0);
    wait_acks(3'b010, 50);
    chk("rd_ack_cyc", 32'(ack_cyc), 32'(t + 5));
    // dead slave timeout, then a stray RVLD
    dead = 1'b1;
    repeat (3) @(negedge CLK);
    single(2, 1'b0, 8'h10, 32'd0, 1'b1);
    chk("to_latency", 32'(ack_cyc - rden_cyc), 32'd65);
    dead = 1'b0;
    n = acks;
    repeat (2) @(negedge CLK);
    force_rvld = 1'b1;
    @(negedge CLK);
    force_rvld = 1'b0;
    repeat (5) @(negedge CLK);
    chk("late_rvld_no_ack", 32'(acks), 32'(n));
    // fairness with all masters writing continuously
    repeat (3) @(negedge CLK);
    n = acks;
    for (int i = 0; i < N; i++) snap[i] = mst_acks[i];
    M_WR = '1;
    M_ADR = {8'h2C, 8'h28, 8'h24};
    M_WDAT = {32'hC0C0C0C2, 32'hB0B0B0B1, 32'hA0A0A0A0};
    for (int g = 0; g < 9; g++) begin
      ptr = (ptr + 1) % N;
      rmem[M_ADR[ptr*AW+2 +: 6]] = M_WDAT[ptr*32 +: 32];
      wq.push_back('{M_ADR[ptr*AW +: AW], M_WDAT[ptr*32 +: 32]});
      aq.push_back('{ptr, 32'd0, 1'b0});
    end
    M_REQ = '1;
    bud = 0;
    while (acks < n + 9 && bud < 200) begin
      @(negedge CLK);
      bud++;
    end
    M_REQ = '0;
    chk("fair_total", 32'(acks - n), 32'd9);
    for (int i = 0; i < N; i++) chk($sformatf("fair_count_m%0d", i), 32'(mst_acks[i] - snap[i]), 32'd3);
    // back-to-back reads from one master
    repeat (3) @(negedge CLK);
    single(0, 1'b0, 8'h04, 32'd0, 1'b0);
    single(0, 1'b0, 8'h28, 32'd0, 1'b0);
    // randomized batches
    for (int it = 0; it < 40; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      wrv = N'($urandom);
      for (int i = 0; i < N; i++) begin
        adrv[i*AW +: AW] = AW'($urandom_range(0, 15) * 4);
        wdv[i*32 +: 32] = $urandom;
      end
      issue(mask, wrv, adrv, wdv, 1'b0);
      wait_acks(mask, 400);
      repeat ($urandom_range(0, 3)) @(negedge CLK);
    end
    // reset in the middle of a read abandons it
    repeat (4) @(negedge CLK);
    M_WR = '0;
    M_ADR = AWT'(8'h0C);
    M_REQ = 3'b001;
    rq.push_back(8'h0C);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    M_REQ = '0;
    @(negedge CLK);
    chk_idle("midrst");
    RST = 1'b0;
    ptr = N - 1;
    n = acks;
    repeat (4) @(negedge CLK);
    chk("midrst_no_ack", 32'(acks), 32'(n));
    issue(3'b011, 3'b011, {8'h00, 8'h34, 8'h30}, {32'd0, 32'h11112222, 32'h33334444}, 1'b0);
    wait_acks(3'b011, 100);
    repeat (10) @(negedge CLK);
    chk("aq_drained", 32'(aq.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
